// File: rtl/instr_encoder.sv
// instr_encoder: re-encodes a decoded instruction into an RV32I/Zicsr machine word
// and buffers the result in a small output FIFO. Each entry carries an illegal flag.
package instruction;
    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK, OP_MRET, OP_WFI,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
        OP_INVALID
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] csr;
        logic [31:0] imm;
    } t;
endpackage

module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  instruction::t      in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_word,
    output logic               out_illegal,
    input  logic               flush,
    output logic [CNT_W-1:0]   encoded_count,
    output logic [CNT_W-1:0]   illegal_count
);
    import instruction::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        i_ok, b_ok, j_ok, u_ok, sh_ok;
    logic [31:0] raw_word;
    logic        enc_bad;
    logic [31:0] enc_word;

    assign imm = in_instr.imm;
    assign rd  = in_instr.rd;
    assign rs1 = in_instr.rs1;
    assign rs2 = in_instr.rs2;

    // Immediate range checks shared by the encoding classes.
    assign i_ok  = (imm[31:12] == {20{imm[11]}});
    assign b_ok  = (imm[31:13] == {19{imm[12]}}) && !imm[0];
    assign j_ok  = (imm[31:21] == {11{imm[20]}}) && !imm[0];
    assign u_ok  = (imm[11:0] == 12'h000);
    assign sh_ok = (imm[31:5] == 27'd0);

    // funct3/funct7 lookup per op; classes below only pick the field layout.
    always_comb begin
        f3 = 3'b000;
        f7 = 7'b0000000;
        case (in_instr.op)
            OP_BNE, OP_LH, OP_SH, OP_SLLI, OP_SLL, OP_CSRRW:      f3 = 3'b001;
            OP_LW, OP_SW, OP_SLTI, OP_SLT, OP_CSRRS:              f3 = 3'b010;
            OP_SLTIU, OP_SLTU, OP_CSRRC:                          f3 = 3'b011;
            OP_BLT, OP_LBU, OP_XORI, OP_XOR:                      f3 = 3'b100;
            OP_BGE, OP_LHU, OP_SRLI, OP_SRL, OP_CSRRWI:           f3 = 3'b101;
            OP_SRAI, OP_SRA:                                      f3 = 3'b101;
            OP_BLTU, OP_ORI, OP_OR, OP_CSRRSI:                    f3 = 3'b110;
            OP_BGEU, OP_ANDI, OP_AND, OP_CSRRCI:                  f3 = 3'b111;
            default:                                              f3 = 3'b000;
        endcase
        if (in_instr.op == OP_SUB || in_instr.op == OP_SRA || in_instr.op == OP_SRAI)
            f7 = 7'b0100000;
    end

    // Field packing by encoding class; unencodable words collapse to NOP.
    always_comb begin
        raw_word = NOP_WORD;
        enc_bad  = 1'b0;
        case (in_instr.op)
            OP_LUI:   begin raw_word = {imm[31:12], rd, 7'b0110111}; enc_bad = !u_ok; end
            OP_AUIPC: begin raw_word = {imm[31:12], rd, 7'b0010111}; enc_bad = !u_ok; end
            OP_JAL: begin
                raw_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                enc_bad  = !j_ok;
            end
            OP_JALR: begin raw_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111}; enc_bad = !i_ok; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                raw_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
                enc_bad  = !b_ok;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                raw_word = {imm[11:0], rs1, f3, rd, 7'b0000011};
                enc_bad  = !i_ok;
            end
            OP_SB, OP_SH, OP_SW: begin
                raw_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
                enc_bad  = !i_ok;
            end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin
                raw_word = {imm[11:0], rs1, f3, rd, 7'b0010011};
                enc_bad  = !i_ok;
            end
            OP_SLLI, OP_SRLI, OP_SRAI: begin
                raw_word = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
                enc_bad  = !sh_ok;
            end
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:
                raw_word = {f7, rs2, rs1, f3, rd, 7'b0110011};
            OP_FENCE: begin raw_word = {imm[11:0], rs1, 3'b000, rd, 7'b0001111}; enc_bad = !i_ok; end
            OP_ECALL:  raw_word = {12'h000, rs1, 3'b000, rd, 7'b1110011};
            OP_EBREAK: raw_word = {12'h001, rs1, 3'b000, rd, 7'b1110011};
            OP_MRET:   raw_word = {12'h302, rs1, 3'b000, rd, 7'b1110011};
            OP_WFI:    raw_word = {12'h105, rs1, 3'b000, rd, 7'b1110011};
            OP_CSRRW, OP_CSRRS, OP_CSRRC:
                raw_word = {in_instr.csr, rs1, f3, rd, 7'b1110011};
            OP_CSRRWI, OP_CSRRSI, OP_CSRRCI: begin
                raw_word = {in_instr.csr, imm[4:0], f3, rd, 7'b1110011};
                enc_bad  = !sh_ok;
            end
            default: enc_bad = 1'b1;
        endcase
    end

    assign enc_word = enc_bad ? NOP_WORD : raw_word;

    // ---------------- output FIFO ----------------
    logic [32:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [31:0]       out_word_q, out_word_d;
    logic              out_ill_q, out_ill_d;
    logic [CNT_W-1:0]  enc_cnt_q, ill_cnt_q;
    logic              push, pop;

    assign in_ready    = (count_q < (AW+1)'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign out_word    = out_word_q;
    assign out_illegal = out_ill_q;
    assign encoded_count = enc_cnt_q;
    assign illegal_count = ill_cnt_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Storage array, written on push; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {enc_bad, enc_word};
    end

    // Next pointers/count and next head word; a push into an empty slot bypasses the array.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_word_d = out_word_q;
        out_ill_d  = out_ill_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (count_d != '0) begin
                if (push && (wr_ptr_q == rd_ptr_d)) begin
                    out_word_d = enc_word;
                    out_ill_d  = enc_bad;
                end else begin
                    out_word_d = mem_q[rd_ptr_d][31:0];
                    out_ill_d  = mem_q[rd_ptr_d][32];
                end
            end
        end
    end

    // Control state, registered head and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_word_q <= '0;
            out_ill_q  <= 1'b0;
            enc_cnt_q  <= '0;
            ill_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_word_q <= out_word_d;
            out_ill_q  <= out_ill_d;
            if (push) begin
                enc_cnt_q <= enc_cnt_q + 1'b1;
                if (enc_bad) ill_cnt_q <= ill_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: encodings, illegal flagging, FIFO flow control.
module tb_instr_encoder;
    import instruction::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    instruction::t in_instr;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_word;
    logic          out_illegal;
    logic          flush = 1'b0;
    logic [31:0]   encoded_count;
    logic [31:0]   illegal_count;

    int errors = 0;
    int checks = 0;

    instr_encoder #(.DEPTH(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_illegal(out_illegal),
        .flush(flush),
        .encoded_count(encoded_count), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    function automatic instruction::t mk(op_e op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [4:0] rs2, logic [11:0] csr, logic [31:0] imm);
        instruction::t x;
        x.op = op; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.csr = csr; x.imm = imm;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_instr = mk(OP_ADDI, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_word !== 32'h0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b ready=%b word=%h ill=%b want 0 1 00000000 0",
                     out_valid, in_ready, out_word, out_illegal);
        end
        checks++;
        if (encoded_count !== 0 || illegal_count !== 0) begin
            errors++;
            $display("FAIL reset_counters: enc=%0d ill=%0d want 0 0", encoded_count, illegal_count);
        end
        $display("reset: valid=%b ready=%b word=%h", out_valid, in_ready, out_word);
    endtask

    task automatic test_nop();
        in_instr = mk(OP_ADDI, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h00000013 || out_illegal !== 1'b0 || encoded_count !== 1) begin
            errors++;
            $display("FAIL nop: valid=%b word=%h ill=%b enc=%0d want 1 00000013 0 1",
                     out_valid, out_word, out_illegal, encoded_count);
        end
        $display("nop: word=%h", out_word);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_word !== 32'h00000013) begin
            errors++;
            $display("FAIL empty_hold: valid=%b word=%h want 0 00000013", out_valid, out_word);
        end
    endtask

    task automatic test_sequence();
        instruction::t seq [3];
        logic [31:0]   exp [3];
        seq[0] = mk(OP_ADDI, 1, 0, 0, 0, 32'd5);         exp[0] = 32'h00500093;
        seq[1] = mk(OP_LUI, 5, 0, 0, 0, 32'h12345000);   exp[1] = 32'h123452B7;
        seq[2] = mk(OP_BEQ, 0, 1, 2, 0, 32'd8);          exp[2] = 32'h00208463;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_instr = seq[i];
            in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_word !== exp[i] || out_illegal !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d: valid=%b word=%h ill=%b want 1 %h 0", i, out_valid, out_word, out_illegal, exp[i]);
            end
            $display("seq %0d: word=%h", i, out_word);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || encoded_count !== 4) begin
            errors++;
            $display("FAIL seq_drain: valid=%b enc=%0d want 0 4", out_valid, encoded_count);
        end
    endtask

    task automatic test_csr_illegal();
        out_ready = 1'b1;
        in_instr = mk(OP_CSRRW, 0, 1, 0, 12'h305, 0);
        in_valid = 1'b1;
        tick();
        checks++;
        if (out_word !== 32'h30509073 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL csrrw: word=%h ill=%b want 30509073 0", out_word, out_illegal);
        end
        $display("csrrw: word=%h", out_word);
        in_instr = mk(OP_ADDI, 0, 0, 0, 0, 32'h00000800);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_word !== 32'h00000013 || out_illegal !== 1'b1 || illegal_count !== 1) begin
            errors++;
            $display("FAIL addi_range: word=%h ill=%b illcnt=%0d want 00000013 1 1", out_word, out_illegal, illegal_count);
        end
        $display("addi 0x800: word=%h ill=%b", out_word, out_illegal);
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        instruction::t w [3];
        logic [31:0]   exp [3];
        w[0] = mk(OP_ADDI, 2, 3, 0, 0, 32'hFFFFFFFF);   exp[0] = 32'hFFF18113;
        w[1] = mk(OP_SW, 0, 2, 5, 0, 32'd12);            exp[1] = 32'h00512623;
        w[2] = mk(OP_JAL, 1, 0, 0, 0, 32'h10);           exp[2] = 32'h010000EF;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = w[0];
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_word !== exp[0]) begin
            errors++;
            $display("FAIL bp_first: ready=%b word=%h want 1 %h", in_ready, out_word, exp[0]);
        end
        in_instr = w[1];
        tick();
        in_instr = w[2];
        checks++;
        if (in_ready !== 1'b0 || out_word !== exp[0]) begin
            errors++;
            $display("FAIL bp_full: ready=%b word=%h want 0 %h", in_ready, out_word, exp[0]);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_word !== exp[0] || encoded_count !== 8) begin
            errors++;
            $display("FAIL bp_held: ready=%b word=%h enc=%0d want 0 %h 8", in_ready, out_word, encoded_count, exp[0]);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_word !== exp[i]) begin
                errors++;
                $display("FAIL bp_drain_%0d: valid=%b word=%h want 1 %h", i, out_valid, out_word, exp[i]);
            end
            $display("drain %0d: word=%h", i, out_word);
            if (i == 2) in_valid = 1'b0;
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || encoded_count !== 9) begin
            errors++;
            $display("FAIL bp_end: valid=%b enc=%0d want 0 9", out_valid, encoded_count);
        end
    endtask

    task automatic test_push_pop();
        in_instr = mk(OP_ADD, 3, 1, 2, 0, 0);
        in_valid = 1'b1;
        tick();
        checks++;
        if (out_word !== 32'h002081B3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add: word=%h ready=%b want 002081b3 1", out_word, in_ready);
        end
        in_instr = mk(OP_SUB, 3, 1, 2, 0, 0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_word !== 32'h402081B3) begin
            errors++;
            $display("FAIL pushpop: valid=%b ready=%b word=%h want 1 1 402081b3", out_valid, in_ready, out_word);
        end
        $display("push+pop: word=%h", out_word);
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_count: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = mk(OP_SRAI, 1, 1, 0, 0, 32'd3);
        tick();
        in_instr = mk(OP_SLLI, 1, 1, 0, 0, 32'd32);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_word !== 32'h4030D093 || illegal_count !== 2) begin
            errors++;
            $display("FAIL pre_flush: ready=%b word=%h illcnt=%0d want 0 4030d093 2", in_ready, out_word, illegal_count);
        end
        flush = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || encoded_count !== 13 || illegal_count !== 2) begin
            errors++;
            $display("FAIL flush: valid=%b ready=%b enc=%0d ill=%0d want 0 1 13 2",
                     out_valid, in_ready, encoded_count, illegal_count);
        end
        in_instr = mk(OP_ADDI, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || encoded_count !== 13) begin
            errors++;
            $display("FAIL flush_drop: valid=%b enc=%0d want 0 13", out_valid, encoded_count);
        end
        $display("flush: valid=%b enc=%0d", out_valid, encoded_count);
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        in_instr = mk(OP_ADDI, 1, 0, 0, 0, 32'd5);
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: valid=%b ready=%b want 1 0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_word !== 32'h0 ||
            encoded_count !== 0 || illegal_count !== 0) begin
            errors++;
            $display("FAIL async_reset: valid=%b ready=%b word=%h enc=%0d ill=%0d want 0 1 0 0 0",
                     out_valid, in_ready, out_word, encoded_count, illegal_count);
        end
        $display("async reset: valid=%b enc=%0d", out_valid, encoded_count);
        tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        in_instr = mk(OP_EBREAK, 0, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_word !== 32'h00100073 || encoded_count !== 1) begin
            errors++;
            $display("FAIL post_reset: word=%h enc=%0d want 00100073 1", out_word, encoded_count);
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_sequence();
        test_csr_illegal();
        test_back_to_back();
        test_push_pop();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the decode stage: takes a decoded `instruction::t` (op, rd/rs1/rs2 addresses, csr, 32-bit immediate) and re-encodes it into a 32-bit RV32I/Zicsr machine word.
- Sits beside the pipeline and feeds the trace port and the debug instruction injector. Both consume raw machine words.
- Valid/ready handshake on both sides, a small output FIFO for buffering, and per-word illegal flagging.

Parameters:
- DEPTH, 2: output FIFO entries (power of two, ≥2).
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction presented.
- in_ready  out  1  encoder can accept; equals (count < DEPTH).
- in_instr  in  $bits(instruction::t)  decoded instruction struct.
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  consumer takes the head word.
- out_word  out  32  encoded machine word at FIFO head.
- out_illegal  out  1  head word was unencodable (word replaced by NOP).
- flush  in  1  synchronous clear of FIFO contents.
- encoded_count  out  CNT_W  words pushed since reset.
- illegal_count  out  CNT_W  illegal words pushed since reset.

Behaviour:
- Reset (async assert, sync deassert use): FIFO empty, rd/wr pointers 0, count 0.
  - out_valid=0, out_word=0, out_illegal=0, in_ready=1, both counters 0.
- Push when in_valid & in_ready. Encoding is combinational on in_instr and written into the FIFO at that edge.
- Pop when out_valid & out_ready.
- Latency: word accepted at edge N is visible at out_word/out_valid after edge N (one cycle) when the FIFO was empty.
- Words leave in acceptance order.
- out_word and out_illegal are the registered FIFO head; they are stable while out_valid & !out_ready.
- Encoding classes, selected by op:
  - R: funct7|rs2|rs1|funct3|rd|0110011.
  - I-ALU/load/JALR: imm[11:0]|rs1|funct3|rd|opcode.
  - Shifts: funct7 with imm[4:0] as shamt; illegal if imm[31:5] != 0.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011.
  - B: imm[12|10:5]|rs2|rs1|funct3|imm[4:1|11]|1100011.
  - U (LUI/AUIPC): imm[31:12]|rd|opcode.
  - J (JAL): imm[20|10:1|11|19:12]|rd|1101111.
  - CSR: csr|rs1 (or imm[4:0] for the I-variants)|funct3|rd|1110011.
  - ECALL/EBREAK/MRET/WFI/FENCE: fixed encodings with the address fields applied.
- Illegal detection (out_illegal=1; stored word forced to 0x00000013):
  - I/S immediate not the sign-extension of its low 12 bits.
  - B immediate not a 13-bit sign-extension, or bit0 set.
  - J immediate not a 21-bit sign-extension, or bit0 set.
  - U immediate with bits[11:0] != 0.
  - CSR immediate variant with imm[31:5] != 0.
  - Any op without an encoding.
- Full: in_ready=0, and in_valid is ignored. Simultaneous push and pop while full cannot happen, because in_ready is already low.
- Empty: out_valid=0 and out_word holds its last value; out_ready is ignored.
- Simultaneous push and pop at 0 < count < DEPTH: count unchanged.
- Pointers wrap modulo DEPTH.
- flush: count and pointers go to 0 at the next edge, and any push in the same cycle is dropped. Counters are not cleared.
- Counters: encoded_count increments on each push; illegal_count increments on each illegal push. Both wrap at 2^CNT_W.
- Reset asserted mid-transfer: everything returns to its reset values immediately, and in-flight words are lost.

Test Plan:
- Push NOP (ADDI, all fields 0, imm 0) → out_word 0x00000013 one cycle later, out_illegal=0, encoded_count=1.
- Push ADDI rd=1 rs1=0 imm=5, then LUI rd=5 imm=0x12345000, then BEQ rs1=1 rs2=2 imm=8, with out_ready=1 → 0x00500093, 0x123452B7, 0x00208463 in order.
- Push CSRRW rd=0 rs1=1 csr=0x305 → 0x30509073. Push ADDI imm=0x00000800 → out_word 0x00000013, out_illegal=1, illegal_count=1.
- Hold out_ready=0 and push 3 words → in_ready falls after 2 pushes, the third is held off, and out_word stays at the first word. Then set out_ready=1 with continuous in_valid → all 3 words emerge in order with no loss.
- Push/pop in the same cycle at count=1 → count stays 1. Assert flush with 2 entries → out_valid=0 next cycle and in_ready=1.
- Assert rst_n=0 asynchronously with 2 entries queued → out_valid and the counters drop to 0 before the next edge.
